// File: rtl/alu_mp_seq_if.sv
// Control-unit side handshake and operand/result bus of the multi-precision ALU sequencer.
interface alu_mp_seq_if #(
    parameter int BYTES = 2
);
    localparam int W = 8 * BYTES;

    logic         start;
    logic [1:0]   op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         res_zero;
    logic         res_carry;

    modport master (
        output start, op, op_a, op_b,
        input  busy, done, result, res_zero, res_carry
    );

    modport slave (
        input  start, op, op_a, op_b,
        output busy, done, result, res_zero, res_carry
    );
endinterface

// File: rtl/alu_mp_seq.sv
// Multi-precision sequencer: runs BYTES-wide ADD/SUB/AND/OR through the 8-bit ALU,
// one limb per ALU operation, least-significant limb first.
module alu_mp_seq #(
    parameter int BYTES = 2
) (
    input  logic       clk,
    input  logic       reset,
    alu_mp_seq_if.slave host,
    output logic       alu_enable,
    output logic [2:0] alu_mode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_out,
    input  logic       alu_zero,
    input  logic       alu_carry
);
    localparam int W  = 8 * BYTES;
    localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_ADC = 3'd1;
    localparam logic [2:0] ALU_INC = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_EXEC, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_OR} op_t;

    state_t       state_q, state_d;
    op_t          op_q, op_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [IW-1:0] idx_q, idx_d;
    logic         zacc_q, zacc_d;
    logic [W-1:0] result_q, result_d;
    logic         res_zero_q, res_zero_d;
    logic         res_carry_q, res_carry_d;
    logic [7:0]   a_byte, b_byte;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        zacc_d      = zacc_q;
        result_d    = result_q;
        res_zero_d  = res_zero_q;
        res_carry_d = res_carry_q;
        alu_enable  = 1'b0;
        alu_mode    = ALU_ADD;
        alu_a       = '0;
        alu_b       = '0;
        a_byte      = a_q[idx_q*8 +: 8];
        b_byte      = b_q[idx_q*8 +: 8];

        case (state_q)
            S_IDLE: begin
                if (host.start) begin
                    op_d    = op_t'(host.op);
                    a_d     = host.op_a;
                    b_d     = host.op_b;
                    idx_d   = '0;
                    zacc_d  = 1'b1;
                    state_d = (op_t'(host.op) == OP_SUB) ? S_PRIME : S_EXEC;
                end
            end
            // 0xFF + 1 leaves the ALU carry set, supplying the +1 of two's-complement subtract.
            S_PRIME: begin
                alu_enable = 1'b1;
                alu_mode   = ALU_INC;
                alu_a      = 8'hFF;
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                alu_enable = 1'b1;
                alu_a      = a_byte;
                case (op_q)
                    OP_ADD: begin
                        alu_mode = (idx_q == '0) ? ALU_ADD : ALU_ADC;
                        alu_b    = b_byte;
                    end
                    OP_SUB: begin
                        alu_mode = ALU_ADC;
                        alu_b    = ~b_byte;
                    end
                    OP_AND: begin
                        alu_mode = ALU_AND;
                        alu_b    = b_byte;
                    end
                    default: begin
                        alu_mode = ALU_OR;
                        alu_b    = b_byte;
                    end
                endcase
                state_d = S_WAIT;
            end
            S_WAIT: begin
                result_d[idx_q*8 +: 8] = alu_out;
                zacc_d = zacc_q & alu_zero;
                // Flags are registered on the way into DONE so they are valid alongside done.
                if (idx_q == IW'(BYTES - 1)) begin
                    res_zero_d  = zacc_q & alu_zero;
                    res_carry_d = (op_q == OP_ADD || op_q == OP_SUB) ? alu_carry : 1'b0;
                    state_d     = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            zacc_q      <= 1'b0;
            result_q    <= '0;
            res_zero_q  <= 1'b0;
            res_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            zacc_q      <= zacc_d;
            result_q    <= result_d;
            res_zero_q  <= res_zero_d;
            res_carry_q <= res_carry_d;
        end
    end

    assign host.busy      = (state_q != S_IDLE);
    assign host.done      = (state_q == S_DONE);
    assign host.result    = result_q;
    assign host.res_zero  = res_zero_q;
    assign host.res_carry = res_carry_q;
endmodule

// File: tb/tb_alu_mp_seq.sv
// Bench for alu_mp_seq: behavioural ALU, wide-arithmetic reference model and per-cycle compare.
module tb_alu_mp_seq;
    localparam int BYTES = 2;
    localparam int W     = 8 * BYTES;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alu_enable;
    logic [2:0] alu_mode;
    logic [7:0] alu_a, alu_b;
    logic [7:0] alu_out_r = '0;
    logic       alu_zero_r = 1'b0;
    logic       alu_carry_r = 1'b0;
    logic       preload_c = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_mp_seq_if #(.BYTES(BYTES)) bus ();

    alu_mp_seq #(.BYTES(BYTES)) dut (
        .clk       (clk),
        .reset     (reset),
        .host      (bus),
        .alu_enable(alu_enable),
        .alu_mode  (alu_mode),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out_r),
        .alu_zero  (alu_zero_r),
        .alu_carry (alu_carry_r)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    // 8-bit ALU: returns {zero, carry, out}
    function automatic logic [9:0] alu_f(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                                         input logic c);
        logic [8:0] s;
        case (m)
            3'd0:    s = {1'b0, a} + {1'b0, b};
            3'd1:    s = {1'b0, a} + {1'b0, b} + {8'd0, c};
            3'd3:    s = {1'b0, a} + 9'd1;
            3'd4:    s = {1'b0, a & b};
            3'd5:    s = {1'b0, a | b};
            default: s = '0;
        endcase
        return {(s[7:0] == 8'd0), s[8], s[7:0]};
    endfunction

    always @(posedge clk) begin
        if (preload_c) alu_carry_r <= 1'b1;
        else if (alu_enable)
            {alu_zero_r, alu_carry_r, alu_out_r} <= alu_f(alu_mode, alu_a, alu_b, alu_carry_r);
    end

    // Wide reference: returns {carry, result}
    function automatic logic [W:0] ref_calc(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {(a >= b), a - b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    logic         m_busy;
    int           m_cyc, m_lat;
    logic [1:0]   m_op;
    logic [W-1:0] m_a, m_b, m_res, h_res;
    logic         m_c, h_z, h_c;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_cyc  <= 0;
            h_res  <= '0;
            h_z    <= 1'b0;
            h_c    <= 1'b0;
        end else if (!m_busy) begin
            if (bus.start) begin
                m_busy <= 1'b1;
                m_cyc  <= 1;
                m_op   <= bus.op;
                m_a    <= bus.op_a;
                m_b    <= bus.op_b;
                {m_c, m_res} <= ref_calc(bus.op, bus.op_a, bus.op_b);
                m_lat  <= (bus.op == 2'd1) ? 2 * BYTES + 2 : 2 * BYTES + 1;
            end
        end else if (m_cyc == m_lat) begin
            m_busy <= 1'b0;
            m_cyc  <= 0;
            h_res  <= m_res;
            h_z    <= (m_res == '0);
            h_c    <= m_c;
        end else begin
            m_cyc <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin : cmp
        int  off, idx;
        bit  sub, exp_done, exp_en;
        logic [2:0] e_mode;
        logic [7:0] e_a, e_b;
        if (!reset) begin
            exp_done = m_busy && (m_cyc == m_lat);
            check("busy", bus.busy, m_busy);
            check("done", bus.done, exp_done);
            if (exp_done) begin
                check("result", bus.result, m_res);
                check("res_zero", bus.res_zero, (m_res == '0));
                check("res_carry", bus.res_carry, m_c);
            end
            if (!m_busy) begin
                check("held_result", bus.result, h_res);
                check("held_zero", bus.res_zero, h_z);
                check("held_carry", bus.res_carry, h_c);
                check("idle_alu_enable", alu_enable, 1'b0);
            end else begin
                sub    = (m_op == 2'd1);
                off    = m_cyc - (sub ? 1 : 0);
                exp_en = 1'b0;
                e_mode = 3'd0;
                e_a    = 8'd0;
                e_b    = 8'd0;
                if (sub && m_cyc == 1) begin
                    exp_en = 1'b1;
                    e_mode = 3'd3;
                    e_a    = 8'hFF;
                end else if ((off % 2) == 1 && off <= 2 * BYTES - 1) begin
                    exp_en = 1'b1;
                    idx    = (off - 1) / 2;
                    e_a    = m_a[idx*8 +: 8];
                    e_b    = m_b[idx*8 +: 8];
                    case (m_op)
                        2'd0: e_mode = (idx == 0) ? 3'd0 : 3'd1;
                        2'd1: begin e_mode = 3'd1; e_b = ~e_b; end
                        2'd2: e_mode = 3'd4;
                        default: e_mode = 3'd5;
                    endcase
                end
                check("alu_enable", alu_enable, exp_en);
                if (exp_en) begin
                    check("alu_mode", alu_mode, e_mode);
                    check("alu_a", alu_a, e_a);
                    check("alu_b", alu_b, e_b);
                end
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit lit, input logic [W-1:0] er, input logic ec, input logic ez);
        int n;
        logic [2:0] first_mode;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.op_a  = a;
        bus.op_b  = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_a  = ~a;
        bus.op_b  = ~b;
        n = 1;
        first_mode = alu_mode;
        case (op)
            2'd0: check("first_mode_add", first_mode, 3'd0);
            2'd1: begin
                check("first_mode_prime", first_mode, 3'd3);
                check("prime_alu_a", alu_a, 8'hFF);
            end
            2'd2: check("first_mode_and", first_mode, 3'd4);
            default: check("first_mode_or", first_mode, 3'd5);
        endcase
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, (op == 2'd1) ? 6 : 5);
        if (lit) begin
            check("lit_result", bus.result, er);
            check("lit_carry", bus.res_carry, ec);
            check("lit_zero", bus.res_zero, ez);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_result", bus.result, 16'h0000);
        check("rst_res_zero", bus.res_zero, 1'b0);
        check("rst_res_carry", bus.res_carry, 1'b0);
        check("rst_alu_enable", alu_enable, 1'b0);
        check("rst_alu_mode", alu_mode, 3'd0);
        check("rst_alu_a", alu_a, 8'h00);
        check("rst_alu_b", alu_b, 8'h00);
        reset = 1'b0;

        run_op(2'd0, 16'h12FF, 16'h0001, 1, 16'h1300, 1'b0, 1'b0);
        @(negedge clk);
        preload_c = 1'b1;
        @(negedge clk);
        preload_c = 1'b0;
        run_op(2'd0, 16'hFFFF, 16'h0001, 1, 16'h0000, 1'b1, 1'b1);
        run_op(2'd1, 16'h1000, 16'h0001, 1, 16'h0FFF, 1'b1, 1'b0);
        run_op(2'd1, 16'h0005, 16'h0006, 1, 16'hFFFF, 1'b0, 1'b0);
        run_op(2'd2, 16'hF0F0, 16'h0F0F, 1, 16'h0000, 1'b0, 1'b1);
        run_op(2'd3, 16'hF0F0, 16'h0F0F, 1, 16'hFFFF, 1'b0, 1'b0);

        // start held high: one accept per IDLE visit, three ADDs in 18 cycles
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.op_a  = 16'h0102;
        bus.op_b  = 16'h0304;
        dones = 0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        bus.start = 1'b0;
        check("held_start_dones", dones, 3);
        check("held_start_result", bus.result, 16'h0406);

        // reset during the first WAIT of an ADD
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.op_a  = 16'h0034;
        bus.op_b  = 16'h0012;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_done", bus.done, 1'b0);
        check("midrst_result", bus.result, 16'h0000);
        check("midrst_alu_enable", alu_enable, 1'b0);
        reset = 1'b0;
        run_op(2'd0, 16'h0001, 16'h0001, 1, 16'h0002, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = W'($urandom);
            rb  = W'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            if ($urandom_range(0, 3) == 0) repeat (2) @(negedge clk);
            run_op(rop, ra, rb, 0, '0, 1'b0, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
